// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor
// cell per clock. A start/busy/done handshake lets a controlling FSM launch
// an operation and collect the registered result WIDTH+1 cycles later.
//
// Optional feature: define SUB_OVF_EN to add the 'ovf' output, which flags
// signed two's-complement overflow of the subtraction.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic             borrow;
  logic [CW-1:0]    cnt;

`ifdef SUB_OVF_EN
  // Sign bits of the captured operands; a_sh/b_sh lose them while shifting.
  logic             a_sign;
  logic             b_sign;
`endif

  logic             bit_d;
  logic             borrow_nxt;
  logic [WIDTH-1:0] r_nxt;
  logic             last_bit;

  // Full-subtractor cell on the current LSBs, plus the result register as it will look after this bit.
  always_comb begin
    bit_d      = a_sh[0] ^ b_sh[0] ^ borrow;
    borrow_nxt = (~a_sh[0] & b_sh[0]) | (~a_sh[0] & borrow) | (b_sh[0] & borrow);
    r_nxt      = {bit_d, r_sh[WIDTH-1:1]};
    last_bit   = (cnt == CNT_LAST);
  end

  // Control FSM and serial datapath; busy/done are registered alongside the state so they are glitch-free Moore outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef SUB_OVF_EN
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            r_sh   <= '0;
            borrow <= bin;
            cnt    <= '0;
`ifdef SUB_OVF_EN
            a_sign <= a[WIDTH-1];
            b_sign <= b[WIDTH-1];
`endif
            state  <= SHIFT;
            busy   <= 1'b1;
            done   <= 1'b0;
          end else begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
          end
        end

        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          r_sh   <= r_nxt;
          borrow <= borrow_nxt;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            diff  <= r_nxt;
            bout  <= borrow_nxt;
`ifdef SUB_OVF_EN
            ovf   <= (a_sign != b_sign) & (r_nxt[WIDTH-1] != a_sign);
`endif
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors for serial_subtractor (WIDTH=8).
// A behavioural model tracks, per accepted operation, the clock edge it was
// accepted on and its arithmetic result; a per-cycle compare process checks
// busy/done/diff/bout (and ovf when SUB_OVF_EN is defined) against it, and
// the directed tests pin the model with hand-computed literal values.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
  logic             done;
`ifdef SUB_OVF_EN
  logic             ovf;
`endif

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
`ifdef SUB_OVF_EN
    .ovf   (ovf),
`endif
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int               edge_n   = 0;
  int               acc_edge = 0;
  bit               active   = 1'b0;
  logic [WIDTH-1:0] p_diff   = '0;
  logic             p_bout   = 1'b0;
  logic             p_ovf    = 1'b0;
  logic [WIDTH-1:0] m_diff   = '0;
  logic             m_bout   = 1'b0;
  logic             m_ovf    = 1'b0;
  logic [WIDTH:0]   wide;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        active = 1'b0;
        edge_n = 0;
        m_diff = '0;
        m_bout = 1'b0;
        m_ovf  = 1'b0;
      end else begin
        edge_n++;
        if (active && (edge_n - acc_edge) == WIDTH) begin
          m_diff = p_diff;
          m_bout = p_bout;
          m_ovf  = p_ovf;
        end
        if (start && (!active || (edge_n - acc_edge) >= WIDTH)) begin
          acc_edge = edge_n;
          active   = 1'b1;
          wide     = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
          p_diff   = wide[WIDTH-1:0];
          p_bout   = wide[WIDTH];
          p_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("cyc_busy", 32'(busy), 32'(active && (edge_n - acc_edge) < WIDTH));
      checkOutput("cyc_done", 32'(done), 32'(active && (edge_n - acc_edge) == WIDTH));
      checkOutput("cyc_diff", 32'(diff), 32'(m_diff));
      checkOutput("cyc_bout", 32'(bout), 32'(m_bout));
`ifdef SUB_OVF_EN
      checkOutput("cyc_ovf", 32'(ovf), 32'(m_ovf));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi);
    @(negedge clk);
    a     = av;
    b     = bv;
    bin   = bi;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; returns cycles observed (first sample counts as 1) and busy cycles seen.
  task automatic waitDone(output int cycles, output int busy_cnt);
    cycles   = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cnt++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL done_timeout: got no done after %0d cycles, required one", cycles);
    end
  endtask

  task automatic runOp(input string name, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic bi, input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
    int cyc, bc;
    applyStimulus(av, bv, bi);
    waitDone(cyc, bc);
    checkOutput({name, "_latency"}, 32'(cyc), 32'(WIDTH + 1));
    checkOutput({name, "_busycyc"}, 32'(bc), 32'(WIDTH));
    checkOutput({name, "_diff"}, 32'(diff), 32'(ed));
    checkOutput({name, "_bout"}, 32'(bout), 32'(eb));
`ifdef SUB_OVF_EN
    checkOutput({name, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo !== 1'b0 && eo !== 1'b1) checkOutput({name, "_ovfarg"}, 32'(eo), 32'(0));
`endif
  endtask

  initial begin
    int cyc, bc, extra;

    repeat (2) @(negedge clk);
    checkOutput("rst_diff", 32'(diff), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_done", 32'(done), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic subtractions, underflow, and borrow-in.
    runOp("t1",   8'h0F, 8'h01, 1'b0, 8'h0E, 1'b0, 1'b0);
    runOp("t2a",  8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    runOp("t2b",  8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0);
    runOp("v_ff", 8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0);
    runOp("v_00", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);
    runOp("v_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0);

    // Start and operand changes during SHIFT are ignored.
    applyStimulus(8'h30, 8'h10, 1'b0);
    repeat (2) @(negedge clk);
    a     = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(cyc, bc);
    checkOutput("t3_diff", 32'(diff), 32'(8'h20));
    checkOutput("t3_bout", 32'(bout), 32'(0));
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) extra++;
    end
    checkOutput("t3_extra_done", 32'(extra), 32'(0));

    // Back-to-back: start held in the DONE cycle.
    applyStimulus(8'h44, 8'h11, 1'b0);
    waitDone(cyc, bc);
    checkOutput("t4_first_diff", 32'(diff), 32'(8'h33));
    a     = 8'h10;
    b     = 8'h20;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("t4_busy_now", 32'(busy), 32'(1));
    checkOutput("t4_held_diff", 32'(diff), 32'(8'h33));
    waitDone(cyc, bc);
    checkOutput("t4_latency", 32'(cyc), 32'(WIDTH + 1));
    checkOutput("t4_diff", 32'(diff), 32'(8'hF0));
    checkOutput("t4_bout", 32'(bout), 32'(1));

    // Asynchronous reset mid-SHIFT.
    applyStimulus(8'h55, 8'h22, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_diff", 32'(diff), 32'(0));
    checkOutput("t5_bout", 32'(bout), 32'(0));
    checkOutput("t5_busy", 32'(busy), 32'(0));
    checkOutput("t5_done", 32'(done), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) extra++;
    end
    checkOutput("t5_no_done", 32'(extra), 32'(0));
    runOp("t5_after", 8'h09, 8'h03, 1'b0, 8'h06, 1'b0, 1'b0);

`ifdef SUB_OVF_EN
    runOp("t6a", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    runOp("t6b", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    runOp("t6c", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
